// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks one-hot column drive, debounces press and release,
// reports one key code per accepted press with optional auto-repeat.
// Latency: rows pass a 2-flop synchronizer; key_valid/multi_key are registered pulses.
module keypad_scanner #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 27,
  parameter int DB_CYCLES    = 270000,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = 13500000,
  parameter int REPEAT_RATE  = 2700000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ROWS-1:0]               rows_raw,
  output logic [COLS-1:0]               col_drive,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code,
  output logic                          key_valid,
  output logic                          key_held,
  output logic                          multi_key
);

  localparam int CW      = $clog2(COLS);
  localparam int RW      = $clog2(ROWS);
  localparam int KW      = $clog2(ROWS*COLS);
  localparam int DIV_W   = $clog2(SCAN_DIV + 1);
  localparam int DB_W    = $clog2(DB_CYCLES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [CW-1:0]    COL_LAST  = CW'(COLS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t            state, state_n;
  logic [ROWS-1:0]   rows_m, rows_s;
  logic [ROWS-1:0]   rows_lat, rows_lat_n;
  logic [CW-1:0]     col_idx, col_idx_n, next_col;
  logic [DIV_W-1:0]  div_cnt, div_n;
  logic [DB_W-1:0]   db_cnt, db_n;
  logic [REP_W-1:0]  rep_cnt, rep_n, rep_tgt;
  logic              rep_first, rep_first_n;
  logic              single, single_n;
  logic [KW-1:0]     code_n, new_code;
  logic              valid_n, held_n, multi_n;
  logic [RW-1:0]     row_idx;
  logic              rep_active;

  // Two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clk) begin
    if (reset) begin
      rows_m <= '0;
      rows_s <= '0;
    end else begin
      rows_m <= rows_raw;
      rows_s <= rows_m;
    end
  end

  assign col_drive  = COLS'(1) << col_idx;
  assign next_col   = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
  assign rep_tgt    = rep_first ? REP_FIRST : REP_NEXT;
  assign rep_active = (REPEAT_EN != 0) && single;

  // Encode the latched one-hot row vector and form row*COLS+col
  always_comb begin
    row_idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (rows_lat[i]) row_idx = RW'(i);
    end
    new_code = KW'((32'(row_idx) * COLS) + 32'(col_idx));
  end

  // Next-state and output logic
  always_comb begin
    state_n     = state;
    col_idx_n   = col_idx;
    div_n       = div_cnt;
    db_n        = db_cnt;
    rep_n       = rep_cnt;
    rep_first_n = rep_first;
    single_n    = single;
    rows_lat_n  = rows_lat;
    code_n      = key_code;
    held_n      = key_held;
    valid_n     = 1'b0;
    multi_n     = 1'b0;
    case (state)
      SCAN: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (rows_s != '0) begin
            rows_lat_n = rows_s;
            db_n       = '0;
            state_n    = DEBOUNCE;
          end else begin
            col_idx_n = next_col;
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rows_s != rows_lat) begin
          state_n   = SCAN;
          col_idx_n = next_col;
          div_n     = '0;
        end else if (db_cnt == DB_LAST) begin
          state_n     = HELD;
          held_n      = 1'b1;
          db_n        = '0;
          rep_n       = '0;
          rep_first_n = 1'b1;
          if ($countones(rows_lat) == 1) begin
            single_n = 1'b1;
            valid_n  = 1'b1;
            code_n   = new_code;
          end else begin
            single_n = 1'b0;
            multi_n  = 1'b1;
          end
        end else begin
          db_n = db_cnt + 1'b1;
        end
      end
      HELD: begin
        if (rows_s == '0) begin
          state_n = RELEASE;
          db_n    = '0;
          if (rep_active && rep_cnt != rep_tgt) rep_n = rep_cnt + 1'b1;
        end else if (rep_active) begin
          if (rep_cnt == rep_tgt) begin
            valid_n     = 1'b1;
            rep_n       = '0;
            rep_first_n = 1'b0;
          end else begin
            rep_n = rep_cnt + 1'b1;
          end
        end
      end
      RELEASE: begin
        // Repeat timer keeps running but saturates; it only fires from HELD
        if (rep_active && rep_cnt != rep_tgt) rep_n = rep_cnt + 1'b1;
        if (rows_s != '0) begin
          state_n = HELD;
        end else if (db_cnt == DB_LAST) begin
          state_n   = SCAN;
          held_n    = 1'b0;
          col_idx_n = next_col;
          div_n     = '0;
        end else begin
          db_n = db_cnt + 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      col_idx   <= '0;
      div_cnt   <= '0;
      db_cnt    <= '0;
      rep_cnt   <= '0;
      rep_first <= 1'b0;
      single    <= 1'b0;
      rows_lat  <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      state     <= state_n;
      col_idx   <= col_idx_n;
      div_cnt   <= div_n;
      db_cnt    <= db_n;
      rep_cnt   <= rep_n;
      rep_first <= rep_first_n;
      single    <= single_n;
      rows_lat  <= rows_lat_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
      multi_key <= multi_n;
    end
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of row inputs (2..8).
REQ-002 SHALL have parameter COLS, default 4, number of driven columns (2..8).
REQ-003 SHALL have parameter SCAN_DIV, default 27, clock cycles each column is driven (>=2).
REQ-004 SHALL have parameter DB_CYCLES, default 270000, stable cycles required for press or release (>=2).
REQ-005 SHALL have parameter REPEAT_EN, default 0, 1 enables auto-repeat while held.
REQ-006 SHALL have parameter REPEAT_DELAY, default 13500000, cycles from first key_valid to first repeat.
REQ-007 SHALL have parameter REPEAT_RATE, default 2700000, cycles between subsequent repeats.
REQ-008 SHALL have port clk, input, 1, single clock.
REQ-009 SHALL have port reset, input, 1, synchronous, active-high.
REQ-010 SHALL have port rows_raw, input, ROWS, asynchronous row lines, 1 = contact closed on driven column.
REQ-011 SHALL have port col_drive, output, COLS, one-hot column drive, active-high.
REQ-012 SHALL have port key_code, output, $clog2(ROWS*COLS), index row*COLS+col, held stable between events.
REQ-013 SHALL have port key_valid, output, 1, single-cycle pulse per accepted press or repeat.
REQ-014 SHALL have port key_held, output, 1, high from accepted press until release debounced.
REQ-015 SHALL have port multi_key, output, 1, single-cycle pulse when a debounced press shows more than one row.

Function
REQ-016 SHALL pass rows_raw through a 2-flop synchronizer; all logic uses synchronized rows (rows_s).
REQ-017 SHALL implement states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-018 SCAN: SHALL drive one column for SCAN_DIV cycles, then advance col index, COLS-1 wraps to 0.
REQ-019 SCAN: on last dwell cycle, if rows_s != 0, SHALL latch col index and rows_s, freeze col_drive, enter DEBOUNCE.
REQ-020 DEBOUNCE: SHALL count cycles with rows_s equal to latched vector; any mismatch SHALL return to SCAN at next column, no outputs.
REQ-021 DEBOUNCE: at count DB_CYCLES with exactly one row bit set, SHALL load key_code, pulse key_valid, enter HELD.
REQ-022 DEBOUNCE: at count DB_CYCLES with two or more row bits set, SHALL pulse multi_key, leave key_code and key_valid unchanged, enter HELD.
REQ-023 HELD: key_held SHALL be 1; rows_s == 0 SHALL enter RELEASE.
REQ-024 HELD with REPEAT_EN=1 and a single-row press: SHALL pulse key_valid REPEAT_DELAY cycles after first pulse, then every REPEAT_RATE cycles, same key_code.
REQ-025 RELEASE: SHALL require rows_s == 0 for DB_CYCLES consecutive cycles; any nonzero SHALL return to HELD with repeat timer continuing.
REQ-026 RELEASE complete: key_held SHALL drop, state SHALL return to SCAN at next column after the released one.
REQ-027 col_drive SHALL remain frozen on the latched column in DEBOUNCE, HELD, RELEASE.
REQ-028 Counters SHALL be sized $clog2 of their max value plus 1; no wrap before terminal count.
REQ-029 key_valid and multi_key SHALL never assert in the same cycle; at most one key_valid per cycle.

Reset
REQ-030 On reset: state SCAN, col index 0, col_drive = 1 in bit 0, key_code 0, key_valid 0, key_held 0, multi_key 0, all counters and synchronizer flops 0.
REQ-031 Reset asserted mid-press or mid-repeat SHALL abort with no further pulses; a key still held after reset SHALL be reacquired as a new press.

Verification (ROWS=4, COLS=4, SCAN_DIV=4, DB_CYCLES=8, REPEAT_DELAY=40, REPEAT_RATE=16)
REQ-032 Idle: rows_raw=0 for 64 cycles -> col_drive cycles 0001,0010,0100,1000,0001 every 4 cycles; no pulses.
REQ-033 Clean press: row 2 high while column 1 driven, held 50 cycles -> one key_valid, key_code=9, key_held=1 until 8 cycles after release.
REQ-034 Bounce: row 0 high 3 cycles during column 3 then low -> no key_valid, scan resumes at column 0.
REQ-035 Two rows: rows 1 and 3 high on column 0 -> one multi_key pulse, no key_valid, key_held=1 until released.
REQ-036 Repeat (REPEAT_EN=1): key 5 held 100 cycles -> key_valid pulses at t0, t0+40, t0+56, t0+72, t0+88, all key_code=5.
REQ-037 Reset mid-HELD: reset 1 cycle while key held -> outputs 0, col_drive=0001, key reacquired with new key_valid after scan and DB_CYCLES.
